// File: rtl/apb_regfifo_pkg.sv
// apb_regfifo_pkg: register offsets, bit positions and the APB FSM state type
// shared by the APB register/FIFO completer and its FIFO sub-block.
package apb_regfifo_pkg;

  // Register byte offsets within the 16-byte window
  localparam logic [3:0] CTRL_OFS    = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] DATA_OFS    = 4'h8;
  localparam logic [3:0] SCRATCH_OFS = 4'hC;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions; the FIFO count occupies an 8-bit field
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_CNT_LSB   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_sync_fifo.sv
// apb_sync_fifo: single-clock FIFO with show-ahead head output. Pointers carry
// one extra wrap bit so full and empty are told apart without a separate
// counter. Push and pop qualification uses the flags as they were before the edge.
module apb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign head  = empty ? '0 : mem[rptr[AW-1:0]];

  // Advance the write and read pointers on accepted pushes and pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset because the head output is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/apb_regfifo_slave.sv
// apb_regfifo_slave: APB completer with CTRL/STATUS/DATA/SCRATCH registers.
// DATA writes feed an internal FIFO drained by a local show-ahead pop port.
// Optional feature macro: APB_REGFIFO_IRQ_EN adds the irq port, the CTRL
// irq_en bit and the sticky overflow flag reported in STATUS.
module apb_regfifo_slave
  import apb_regfifo_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              fifo_rd_en,
  output logic [31:0]       fifo_rd_data,
  output logic              fifo_empty
`ifdef APB_REGFIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  apb_state_e  state_q;
  apb_state_e  state_cur;
  apb_state_e  state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_nxt;
  logic        complete;

  logic        addr_ok;
  logic        is_ctrl;
  logic        is_status;
  logic        is_data;
  logic        is_scratch;
  logic        err;
  logic [31:0] rd_val;

  logic        ctrl_enable;
  logic [31:0] scratch;
  logic        fifo_push;
  logic        fifo_full;
  logic [CW-1:0] fifo_count;

`ifdef APB_REGFIFO_IRQ_EN
  logic        ctrl_irq_en;
  logic        ovf;
`endif

  // State register: remembers that the bus is in its access phase and how many
  // wait cycles remain before completion
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state: SETUP is the cycle the master shows PSEL without PENABLE, so it
  // is recognised combinationally and the following cycle is already ACCESS
  always_comb begin
    state_cur = IDLE;
    state_nxt = IDLE;
    wait_nxt  = wait_cnt;
    if (PSEL && !PENABLE) begin
      state_cur = SETUP;
    end else if ((state_q == ACCESS) && PSEL && PENABLE) begin
      state_cur = ACCESS;
    end
    case (state_cur)
      SETUP: begin
        state_nxt = ACCESS;
        wait_nxt  = 4'(WAIT_STATES);
      end
      ACCESS: begin
        if (wait_cnt != 4'd0) begin
          state_nxt = ACCESS;
          wait_nxt  = wait_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs: response data and error are only driven in the completing cycle
  always_comb begin
    complete = (state_cur == ACCESS) && (wait_cnt == 4'd0);
    PREADY   = complete;
    PSLVERR  = complete && err;
    PRDATA   = (complete && !PWRITE && !err) ? rd_val : 32'h0;
  end

  // Address decode, error classification and read mux
  always_comb begin
    addr_ok    = (PADDR[ADDR_W-1:4] == '0) && (PADDR[1:0] == 2'b00);
    is_ctrl    = addr_ok && (PADDR[3:0] == CTRL_OFS);
    is_status  = addr_ok && (PADDR[3:0] == STATUS_OFS);
    is_data    = addr_ok && (PADDR[3:0] == DATA_OFS);
    is_scratch = addr_ok && (PADDR[3:0] == SCRATCH_OFS);
    err = !addr_ok
        || (PWRITE && is_status)
        || (!PWRITE && is_data)
        || (PWRITE && is_data && (!ctrl_enable || fifo_full));
    rd_val = 32'h0;
    if (is_ctrl) begin
      rd_val[CTRL_ENABLE_BIT] = ctrl_enable;
`ifdef APB_REGFIFO_IRQ_EN
      rd_val[CTRL_IRQ_EN_BIT] = ctrl_irq_en;
`endif
    end else if (is_status) begin
      rd_val[STATUS_EMPTY_BIT]          = fifo_empty;
      rd_val[STATUS_FULL_BIT]           = fifo_full;
      rd_val[STATUS_CNT_LSB +: 8]       = 8'(fifo_count);
`ifdef APB_REGFIFO_IRQ_EN
      rd_val[STATUS_OVF_BIT]            = ovf;
`endif
    end else if (is_scratch) begin
      rd_val = scratch;
    end
  end

  assign fifo_push = complete && PWRITE && is_data && !err;

  // Register bank: writes land only on the completion edge of an error-free access
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_enable <= 1'b0;
      scratch     <= 32'h0;
`ifdef APB_REGFIFO_IRQ_EN
      ctrl_irq_en <= 1'b0;
`endif
    end else if (complete && PWRITE && !err) begin
      if (is_ctrl) begin
        ctrl_enable <= PWDATA[CTRL_ENABLE_BIT];
`ifdef APB_REGFIFO_IRQ_EN
        ctrl_irq_en <= PWDATA[CTRL_IRQ_EN_BIT];
`endif
      end
      if (is_scratch) scratch <= PWDATA;
    end
  end

`ifdef APB_REGFIFO_IRQ_EN
  // Sticky overflow set by a DATA write bounced off a full FIFO, cleared by reading STATUS
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ovf <= 1'b0;
    end else if (complete && PWRITE && is_data && fifo_full) begin
      ovf <= 1'b1;
    end else if (complete && !PWRITE && is_status) begin
      ovf <= 1'b0;
    end
  end

  // Registered interrupt so the consumer sees a glitch-free level
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) irq <= 1'b0;
    else          irq <= ctrl_irq_en && (fifo_full || ovf);
  end
`endif

  apb_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (fifo_push),
    .din   (PWDATA),
    .pop   (fifo_rd_en),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_rd_data)
  );

endmodule

// File: tb/tb_apb_regfifo_slave.sv
// tb_apb_regfifo_slave: directed and randomized APB traffic against a
// queue-based model of the register file and FIFO.
// Optional feature macro: APB_REGFIFO_IRQ_EN (irq port and overflow flag).
module tb_apb_regfifo_slave;

  localparam int TB_WAIT  = 2;
  localparam int TB_DEPTH = 8;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty;
`ifdef APB_REGFIFO_IRQ_EN
  logic        irq;
`endif

  int checkCount = 0;
  int errCount   = 0;

  // Reference model state
  bit          mEnable;
  bit          mIrqEn;
  bit          mOvf;
  logic [31:0] mScratch;
  logic [31:0] mFifo[$];

  apb_regfifo_slave #(
    .ADDR_W      (12),
    .FIFO_DEPTH  (TB_DEPTH),
    .WAIT_STATES (TB_WAIT)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty)
`ifdef APB_REGFIFO_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mEnable  = 1'b0;
    mIrqEn   = 1'b0;
    mOvf     = 1'b0;
    mScratch = 32'h0;
    mFifo.delete();
  endtask

  function automatic logic [31:0] modelStatus();
    int n;
    n = mFifo.size();
    return (32'(n) << 8) | (32'(mOvf) << 2) | (32'(n == TB_DEPTH) << 1) | 32'(n == 0);
  endfunction

  // One complete APB transfer, optionally popping the FIFO on the completion edge
  task automatic applyStimulus(input bit wr, input logic [11:0] addr, input logic [31:0] wdata, input bit popAtEnd);
    bit          legal;
    int          idx;
    bit          expErr;
    logic [31:0] expRd;
    bit          wasFull;
    bit          popOk;
    bit          doPush;
    bit          done;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    string       tag;

    tag     = $sformatf("%s@%03h", wr ? "wr" : "rd", addr);
    legal   = (addr[1:0] == 2'b00) && (int'(addr) <= 12);
    idx     = int'(addr) / 4;
    wasFull = (mFifo.size() == TB_DEPTH);
    popOk   = popAtEnd && (mFifo.size() != 0);
    expErr  = 1'b0;
    expRd   = 32'h0;
    doPush  = 1'b0;
    if (!legal) begin
      expErr = 1'b1;
    end else if (wr) begin
      if (idx == 1) expErr = 1'b1;
      if (idx == 2) begin
        if (!mEnable || wasFull) expErr = 1'b1;
        else doPush = 1'b1;
      end
    end else begin
      case (idx)
        0: expRd = {30'h0, mIrqEn, mEnable};
        1: expRd = modelStatus();
        2: expErr = 1'b1;
        default: expRd = mScratch;
      endcase
    end

    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0; waits = 0; rdata = 32'h0; slverr = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge PCLK);
      if (PREADY) begin
        done   = 1'b1;
        rdata  = PRDATA;
        slverr = PSLVERR;
        if (popAtEnd) fifo_rd_en = 1'b1;
      end else begin
        waits++;
        @(posedge PCLK);
      end
    end
    if (done) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; fifo_rd_en = 1'b0;

    checkOutput({tag, "_done"}, 32'(done), 32'h1);
    checkOutput({tag, "_waits"}, 32'(waits), 32'(TB_WAIT));
    checkOutput({tag, "_slverr"}, 32'(slverr), 32'(expErr));
    checkOutput({tag, "_prdata"}, rdata, expRd);

    if (done) begin
      if (wr && !expErr && idx == 0) begin
        mEnable = wdata[0];
`ifdef APB_REGFIFO_IRQ_EN
        mIrqEn  = wdata[1];
`endif
      end
      if (wr && !expErr && idx == 3) mScratch = wdata;
`ifdef APB_REGFIFO_IRQ_EN
      if (wr && legal && idx == 2 && wasFull) mOvf = 1'b1;
      if (!wr && legal && idx == 1) mOvf = 1'b0;
`endif
      if (popOk) void'(mFifo.pop_front());
      if (doPush) mFifo.push_back(wdata);
    end
  endtask

  task automatic popFifo();
    @(posedge PCLK); #1;
    fifo_rd_en = 1'b1;
    @(posedge PCLK); #1;
    fifo_rd_en = 1'b0;
    if (mFifo.size() != 0) void'(mFifo.pop_front());
  endtask

  task automatic checkFifoState(input string tag);
    @(posedge PCLK); #1;
    checkOutput({tag, "_empty"}, 32'(fifo_empty), 32'(mFifo.size() == 0));
    checkOutput({tag, "_head"}, fifo_rd_data, (mFifo.size() != 0) ? mFifo[0] : 32'h0);
`ifdef APB_REGFIFO_IRQ_EN
    checkOutput({tag, "_irq"}, 32'(irq), 32'(mIrqEn && ((mFifo.size() == TB_DEPTH) || mOvf)));
`endif
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_prdata"}, PRDATA, 32'h0);
    checkOutput({tag, "_pready"}, 32'(PREADY), 32'h0);
    checkOutput({tag, "_pslverr"}, 32'(PSLVERR), 32'h0);
    checkOutput({tag, "_empty"}, 32'(fifo_empty), 32'h1);
    checkOutput({tag, "_head"}, fifo_rd_data, 32'h0);
`ifdef APB_REGFIFO_IRQ_EN
    checkOutput({tag, "_irq"}, 32'(irq), 32'h0);
`endif
  endtask

  initial begin
    logic [11:0] addrList[8];
    int          sel;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;

    addrList = '{12'h000, 12'h004, 12'h008, 12'h008, 12'h00C, 12'h010, 12'h002, 12'h804};

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; fifo_rd_en = 1'b0;
    resetModel();
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    checkResetOutputs("reset");

    // Reset values through the bus
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    applyStimulus(1'b0, 12'h000, 32'h0, 1'b0);

    // SCRATCH write/readback with wait states
    applyStimulus(1'b1, 12'h00C, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 12'h00C, 32'h0, 1'b0);

    // Basic FIFO flow
    applyStimulus(1'b1, 12'h000, 32'h1, 1'b0);
    applyStimulus(1'b1, 12'h008, 32'h11, 1'b0);
    applyStimulus(1'b1, 12'h008, 32'h22, 1'b0);
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    checkFifoState("two");
    popFifo();
    checkFifoState("pop1");
    popFifo();
    checkFifoState("pop2");
    popFifo();
    checkFifoState("popEmpty");

    // Fill to full, overflow, full+push+pop, interrupt
    for (int i = 0; i < TB_DEPTH; i++) applyStimulus(1'b1, 12'h008, $urandom, 1'b0);
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    applyStimulus(1'b1, 12'h008, 32'hBAD0BAD0, 1'b0);
    applyStimulus(1'b1, 12'h000, 32'h3, 1'b0);
    checkFifoState("full");
    applyStimulus(1'b1, 12'h008, 32'hCAFE0001, 1'b1);
    checkFifoState("fullPushPop");
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    checkFifoState("ovfClear");

    // Illegal accesses leave state untouched
    applyStimulus(1'b1, 12'h010, 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b0, 12'h010, 32'h0, 1'b0);
    applyStimulus(1'b1, 12'h002, 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b1, 12'h004, 32'hFFFFFFFF, 1'b0);
    applyStimulus(1'b0, 12'h008, 32'h0, 1'b0);
    while (mFifo.size() != 0) popFifo();
    applyStimulus(1'b1, 12'h000, 32'h0, 1'b0);
    applyStimulus(1'b1, 12'h008, 32'h55, 1'b0);
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    applyStimulus(1'b0, 12'h00C, 32'h0, 1'b0);
    checkFifoState("errs");

    // Empty + push + pop: push lands, pop ignored
    applyStimulus(1'b1, 12'h000, 32'h1, 1'b0);
    applyStimulus(1'b1, 12'h008, 32'h77, 1'b1);
    checkFifoState("emptyPushPop");

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        popFifo();
      end else begin
        sel   = $urandom_range(0, 7);
        addr  = addrList[sel];
        wr    = ($urandom_range(0, 2) != 0);
        wdata = $urandom;
        if (addr == 12'h000) wdata[0] = ($urandom_range(0, 3) != 0);
        applyStimulus(wr, addr, wdata, (addr == 12'h008) && ($urandom_range(0, 2) == 0));
      end
      checkFifoState($sformatf("rnd%0d", n));
    end

    // Reset asserted during the access phase of a DATA write
    applyStimulus(1'b1, 12'h000, 32'h1, 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'h99;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    resetModel();
    repeat (2) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    checkResetOutputs("midReset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    checkResetOutputs("postReset");
    applyStimulus(1'b0, 12'h004, 32'h0, 1'b0);
    applyStimulus(1'b0, 12'h000, 32'h0, 1'b0);
    applyStimulus(1'b0, 12'h00C, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
